// File: rtl/bcd_digits_to_binary.sv
// Serial BCD-to-binary entry converter.
// Takes decimal digits most significant first over a valid/ready handshake,
// accumulates value = value*10 + digit, and reports the binary result (or an
// error) with a one-cycle strobe. Results stay on the outputs until the next one.
module bcd_digits_to_binary #(
  parameter int DIGITS    = 3,
  parameter int WIDTH     = 7,
  parameter int MAX_VALUE = 127
) (
  input  logic                          i_clock,
  input  logic                          i_resetn,
  input  logic                          i_clear,
  input  logic [3:0]                    i_digit_in,
  input  logic                          i_digit_valid,
  input  logic                          i_digit_last,
  output logic                          o_digit_ready,
  output logic [WIDTH-1:0]              o_binary_out,
  output logic                          o_result_valid,
  output logic                          o_error,
  output logic [$clog2(DIGITS+1)-1:0]   o_digit_count
);

  // Four extra bits keep acc*10 + 15 from wrapping for any legal acc.
  localparam int AW = WIDTH + 4;
  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_acc;
  logic [CW-1:0]   r_count;
  logic [WIDTH-1:0] r_binary;
  logic            r_error;
  logic            r_result_valid;

  logic            w_accept;
  logic [AW-1:0]   w_new;
  logic            w_digit_err;

  // Candidate accumulator value and the error test for the digit on the bus.
  always_comb begin
    w_accept    = i_digit_valid && o_digit_ready;
    w_new       = r_acc * AW'(10) + AW'(i_digit_in);
    w_digit_err = (i_digit_in > 4'd9) || (w_new > AW'(MAX_VALUE)) ||
                  (r_count == CW'(DIGITS));
  end

  // Entry FSM: accumulate digits, drain after an error, report in DONE.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state        <= IDLE;
      r_acc          <= '0;
      r_count        <= '0;
      r_binary       <= '0;
      r_error        <= 1'b0;
      r_result_valid <= 1'b0;
    end else if (i_clear) begin
      // Abort the number in progress; last reported result stays visible.
      r_state        <= IDLE;
      r_acc          <= '0;
      r_count        <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            if (w_digit_err) begin
              if (i_digit_last) begin
                r_state        <= DONE;
                r_result_valid <= 1'b1;
                r_binary       <= '0;
                r_error        <= 1'b1;
              end else begin
                r_state <= DRAIN;
              end
            end else begin
              r_acc   <= w_new;
              r_count <= r_count + CW'(1);
              if (i_digit_last) begin
                r_state        <= DONE;
                r_result_valid <= 1'b1;
                r_binary       <= w_new[WIDTH-1:0];
                r_error        <= 1'b0;
              end else begin
                r_state <= ACCUM;
              end
            end
          end
        end
        DRAIN: begin
          // Remaining digits of a bad number are swallowed until the last one.
          if (w_accept && i_digit_last) begin
            r_state        <= DONE;
            r_result_valid <= 1'b1;
            r_binary       <= '0;
            r_error        <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_acc   <= '0;
          r_count <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_digit_ready  = (r_state != DONE);
  assign o_binary_out   = r_binary;
  assign o_result_valid = r_result_valid;
  assign o_error        = r_error;
  assign o_digit_count  = r_count;

endmodule
